int8_conv_pe: RTL and testbench

- Single INT8 convolution processing element: a 32-bit multiply-accumulate, then bias add, LeakyReLU and requantize back to INT8.
- Sits after the weight/activation fetch logic in the YOLO layer datapath. It produces one output-channel value per accumulation run, for example 288 MACs for a 32-channel 3x3 kernel.

---
 rtl/int8_pe_pkg.sv | 40 ++++
 rtl/int8_requant_stage.sv | 70 +++++++
 rtl/int8_conv_pe.sv | 133 +++++++++++++
 tb/tb_int8_conv_pe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/int8_pe_pkg.sv
// int8_pe_pkg: shared widths, INT8 limits, default requantize/leaky constants,
// data typedefs and the wrap-or-saturate 32-bit adder used by the PE.
package int8_pe_pkg;

  localparam int ACC_W   = 32;
  localparam int DATA_W  = 8;
  localparam int SCALE_W = 16;
  localparam int PROD_W  = 2 * DATA_W;
  localparam int LK_W    = 36;
  localparam int P_W     = ACC_W + SCALE_W + 1;

  localparam int SCALE_Q_DEF     = 16;
  localparam int LEAKY_MUL_DEF   = 13;
  localparam int LEAKY_SHIFT_DEF = 7;

  typedef logic signed [DATA_W-1:0] int8_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam int8_t INT8_MIN = 8'sh80;
  localparam int8_t INT8_MAX = 8'sh7F;
  localparam acc_t  ACC_MIN  = 32'sh8000_0000;
  localparam acc_t  ACC_MAX  = 32'sh7FFF_FFFF;

  // 32-bit signed add; with sat_en the result clamps to the acc_t range,
  // otherwise it wraps modulo 2^32.
  function automatic acc_t acc_add(input acc_t a, input acc_t b, input logic sat_en);
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sat_en && (sum[ACC_W] != sum[ACC_W-1])) begin
      if (sum[ACC_W]) begin
        acc_add = ACC_MIN;
      end else begin
        acc_add = ACC_MAX;
      end
    end else begin
      acc_add = sum[ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/int8_requant_stage.sv
// int8_requant_stage: registered requantize of a 32-bit leaky result.
// out = clamp(round(y * scale / 2^SCALE_Q), INT8_MIN, INT8_MAX), with
// round-half-up followed by an arithmetic (floor) shift. SCALE_Q must be >= 1.
module int8_requant_stage
  import int8_pe_pkg::*;
#(
  parameter int SCALE_Q = SCALE_Q_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [ACC_W-1:0]   in_y,
  input  logic [SCALE_W-1:0] in_scale,
  output logic [DATA_W-1:0]  out_int8,
  output logic               out_valid
);

  localparam logic signed [P_W-1:0] RND = 49'sd1 <<< (SCALE_Q - 1);

  logic signed [P_W-1:0] p_s;
  logic signed [P_W-1:0] r_s;
  int8_t                 clamp_s;
  int8_t                 out_d, out_q;
  logic                  valid_d, valid_q;

  // Product with zero-extended scale, then round and floor-shift.
  always_comb begin
    p_s = $signed({{(P_W-ACC_W){in_y[ACC_W-1]}}, in_y}) *
          $signed({{(P_W-SCALE_W){1'b0}}, in_scale});
    r_s = (p_s + RND) >>> SCALE_Q;
  end

  // Clamp the rounded value into the INT8 range.
  always_comb begin
    clamp_s = INT8_MIN;
    if (r_s > 49'sd127) begin
      clamp_s = INT8_MAX;
    end else if (r_s < -49'sd128) begin
      clamp_s = INT8_MIN;
    end else begin
      clamp_s = int8_t'(r_s);
    end
  end

  // Output holds its last value until a new result arrives.
  always_comb begin
    valid_d = in_valid;
    out_d   = out_q;
    if (in_valid) begin
      out_d = clamp_s;
    end else begin
      out_d = out_q;
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= 8'sh00;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out_int8  = out_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/int8_conv_pe.sv
// int8_conv_pe: INT8 MAC into a 32-bit accumulator, then bias add, LeakyReLU
// (x*LEAKY_MUL >>> LEAKY_SHIFT for negatives) and requantize to INT8.
// Latency from finish to out_valid is two cycles, fully pipelined.
// Build option: define INT8_PE_ACC_SAT_EN to make the accumulator and the
// bias add saturate to the signed 32-bit range instead of wrapping.
module int8_conv_pe
  import int8_pe_pkg::*;
#(
  parameter int SCALE_Q     = SCALE_Q_DEF,
  parameter int LEAKY_MUL   = LEAKY_MUL_DEF,
  parameter int LEAKY_SHIFT = LEAKY_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               acc_clr,
  input  logic               mac_valid,
  input  logic [DATA_W-1:0]  weight,
  input  logic [DATA_W-1:0]  activation,
  input  logic [ACC_W-1:0]   bias,
  input  logic [SCALE_W-1:0] scale,
  input  logic               finish,
  output logic [ACC_W-1:0]   acc,
  output logic [DATA_W-1:0]  out_int8,
  output logic               out_valid
);

`ifdef INT8_PE_ACC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  localparam logic signed [LK_W-1:0] LEAKY_MUL_W = LK_W'(LEAKY_MUL);

  logic signed [PROD_W-1:0] prod_s;
  acc_t                     acc_base_s;
  acc_t                     acc_d, acc_q;

  acc_t                     x_s;
  logic signed [LK_W-1:0]   lk_prod_s;
  logic signed [LK_W-1:0]   lk_shift_s;
  acc_t                     y_s;

  acc_t                     s1_y_d, s1_y_q;
  logic [SCALE_W-1:0]       s1_scale_d, s1_scale_q;
  logic                     s1_valid_d, s1_valid_q;

  // Full 16-bit signed product of the two INT8 operands.
  always_comb begin
    prod_s = $signed({{DATA_W{weight[DATA_W-1]}}, weight}) *
             $signed({{DATA_W{activation[DATA_W-1]}}, activation});
  end

  // Accumulator next state: clear first, then accumulate if mac_valid.
  always_comb begin
    acc_base_s = acc_q;
    acc_d      = acc_q;
    if (acc_clr) begin
      acc_base_s = {ACC_W{1'b0}};
    end else begin
      acc_base_s = acc_q;
    end
    if (mac_valid) begin
      acc_d = acc_add(acc_base_s, {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s}, SAT_EN);
    end else begin
      acc_d = acc_base_s;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  // Bias add on the pre-update accumulator, then LeakyReLU.
  always_comb begin
    x_s        = acc_add(acc_q, bias, SAT_EN);
    lk_prod_s  = $signed({{(LK_W-ACC_W){x_s[ACC_W-1]}}, x_s}) * LEAKY_MUL_W;
    lk_shift_s = lk_prod_s >>> LEAKY_SHIFT;
    y_s        = x_s;
    if (x_s[ACC_W-1]) begin
      y_s = acc_t'(lk_shift_s);
    end else begin
      y_s = x_s;
    end
  end

  // Stage-1 capture: each finish carries its own leaky value and scale.
  always_comb begin
    s1_valid_d = finish;
    s1_y_d     = s1_y_q;
    s1_scale_d = s1_scale_q;
    if (finish) begin
      s1_y_d     = y_s;
      s1_scale_d = scale;
    end else begin
      s1_y_d     = s1_y_q;
      s1_scale_d = s1_scale_q;
    end
  end

  // Stage-1 registers; reset drops any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_y_q     <= {ACC_W{1'b0}};
      s1_scale_q <= {SCALE_W{1'b0}};
      s1_valid_q <= 1'b0;
    end else begin
      s1_y_q     <= s1_y_d;
      s1_scale_q <= s1_scale_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  int8_requant_stage #(
    .SCALE_Q (SCALE_Q)
  ) u_requant (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid_q),
    .in_y      (s1_y_q),
    .in_scale  (s1_scale_q),
    .out_int8  (out_int8),
    .out_valid (out_valid)
  );

  assign acc = acc_q;

endmodule

// File: tb/tb_int8_conv_pe.sv
// tb_int8_conv_pe: directed bench for int8_conv_pe with a scoreboard of
// expected INT8 results (value and arrival cycle) produced by a longint model.
module tb_int8_conv_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_clr;
  logic        mac_valid;
  logic [7:0]  weight;
  logic [7:0]  activation;
  logic [31:0] bias;
  logic [15:0] scale;
  logic        finish;
  logic [31:0] acc;
  logic [7:0]  out_int8;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  longint mdl_acc = 0;

  typedef struct {
    int    due;
    int    val;
    string tag;
  } exp_t;
  exp_t sb[$];

  int8_conv_pe dut (
    .clk        (clk),
    .rst        (rst),
    .acc_clr    (acc_clr),
    .mac_valid  (mac_valid),
    .weight     (weight),
    .activation (activation),
    .bias       (bias),
    .scale      (scale),
    .finish     (finish),
    .acc        (acc),
    .out_int8   (out_int8),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint fix32(input longint v);
`ifdef INT8_PE_ACC_SAT_EN
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
`else
    logic [31:0] t;
    t = v[31:0];
    return longint'($signed(t));
`endif
  endfunction

  function automatic int model_out(input longint acc_v, input int b, input int s);
    longint x, y, p, r;
    x = fix32(acc_v + longint'(b));
    if (x >= 0) y = x;
    else y = (x * 64'sd13) >>> 7;
    p = y * longint'(s);
    r = (p + 64'sd32768) >>> 16;
    if (r > 127) return 127;
    else if (r < -128) return -128;
    else return int'(r);
  endfunction

  // Drive one cycle of stimulus at a negedge, update the model, advance.
  task automatic drive(input logic clr, input logic mv, input int w, input int a,
                       input logic fin, input int b, input int s, input string tag);
    exp_t   e;
    longint base;
    acc_clr    = clr;
    mac_valid  = mv;
    weight     = 8'(w);
    activation = 8'(a);
    finish     = fin;
    bias       = 32'(b);
    scale      = 16'(s);
    if (fin) begin
      e.due = cyc + 2;
      e.val = model_out(mdl_acc, b, s);
      e.tag = tag;
      sb.push_back(e);
    end
    base = clr ? 64'sd0 : mdl_acc;
    if (mv) mdl_acc = fix32(base + longint'(w * a));
    else    mdl_acc = base;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, "");
  endtask

  task automatic check_acc(input string tag);
    check(tag, longint'($signed(acc)), mdl_acc);
  endtask

  // Scoreboard monitor: compares every out_valid pulse with the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check({sb[0].tag, "_missing"}, cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", longint'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_latency"}, cyc, e.due);
          check(e.tag, longint'($signed(out_int8)), e.val);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; acc_clr = 1'b0; mac_valid = 1'b0; weight = 8'h00; activation = 8'h00;
    bias = 32'h0; scale = 16'h0; finish = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_acc", longint'(acc), 0);
    check("reset_out_int8", longint'(out_int8), 0);
    check("reset_out_valid", longint'(out_valid), 0);
    rst = 1'b0;

    // MAC sequence.
    drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, "");        check_acc("acc_clr");
    drive(1'b0, 1'b1, 3, -4, 1'b0, 0, 0, "");       check_acc("acc_m12");
    check("acc_m12_const", longint'($signed(acc)), -12);
    drive(1'b0, 1'b1, -128, -128, 1'b0, 0, 0, "");  check_acc("acc_16372");
    check("acc_16372_const", longint'($signed(acc)), 16372);
    drive(1'b1, 1'b1, 2, 5, 1'b0, 0, 0, "");        check_acc("acc_clr_mac");
    drive(1'b0, 1'b0, 9, 9, 1'b0, 0, 0, "");        check_acc("acc_hold");

    // Positive path and output hold.
    drive(1'b1, 1'b1, 100, 10, 1'b0, 0, 0, "");     check_acc("acc_1000");
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0, 655, "pos_1000");
    idle(4);
    check("hold_out_int8", longint'($signed(out_int8)), 10);
    check("hold_out_valid", longint'(out_valid), 0);

    // Negative paths.
    drive(1'b1, 1'b1, -100, 10, 1'b0, 0, 0, "");    check_acc("acc_m1000");
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0, 655, "neg_1000");
    idle(3);
    drive(1'b1, 1'b1, 2, 5, 1'b0, 0, 0, "");
    drive(1'b0, 1'b0, 0, 0, 1'b1, -30, 655, "neg_bias");
    idle(3);

    // Saturation of the INT8 result.
    drive(1'b1, 1'b1, 100, 100, 1'b0, 0, 0, "");
    drive(1'b0, 1'b1, 100, 100, 1'b0, 0, 0, "");    check_acc("acc_20000");
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0, 655, "sat_pos");
    drive(1'b1, 1'b1, -100, 100, 1'b0, 0, 0, "");
    for (int i = 0; i < 19; i++) drive(1'b0, 1'b1, -100, 100, 1'b0, 0, 0, "");
    check_acc("acc_m200000");
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0, 655, "sat_neg");
    idle(3);

    // Back-to-back finishes, second one with a same-cycle MAC.
    drive(1'b1, 1'b1, 100, 10, 1'b0, 0, 0, "");
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0, 655, "b2b_first");
    drive(1'b0, 1'b1, 50, 20, 1'b1, 0, 1310, "b2b_second");
    drive(1'b0, 1'b0, 0, 0, 1'b1, 7, 1000, "b2b_third");
    check_acc("acc_after_b2b");
    idle(4);

    // Reset right after finish aborts the in-flight result.
    drive(1'b1, 1'b1, 100, 10, 1'b0, 0, 0, "");
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0, 655, "aborted");
    rst = 1'b1;
    sb.delete();
    mdl_acc = 0;
    finish = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_no_out_valid", longint'(out_valid), 0);
      @(negedge clk);
    end
    check_acc("abort_acc");
    check("abort_out_int8", longint'(out_int8), 0);

    // Overflow of the accumulator from a preloaded value near 2^31-1.
    force dut.acc_q = 32'sd2147483547;
    @(negedge clk);
    release dut.acc_q;
    mdl_acc = 64'sd2147483547;
    idle(1);
    check_acc("acc_preload");
    drive(1'b0, 1'b1, 127, 127, 1'b0, 0, 0, "");
    check_acc("acc_overflow");
`ifdef INT8_PE_ACC_SAT_EN
    check("acc_overflow_const", longint'($signed(acc)), 64'sd2147483647);
`else
    check("acc_overflow_const", longint'($signed(acc)), -64'sd2147467620);
`endif
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1, 655, "ovf_bias");
    idle(4);

    check("scoreboard_drained", longint'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
